// File: rtl/spi_pkg.sv
// Shared definitions for the byte-oriented SPI master: FSM states and default widths.
package spi_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int FIFO_ADDR_WIDTH = 2;
    localparam int SPPR_WIDTH      = 3;
    localparam int SPR_WIDTH       = 3;

    typedef enum logic [1:0] {
        stIdle  = 2'd0,
        stShift = 2'd1,
        stGap   = 2'd2
    } state_t;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous first-word-fall-through FIFO used for both the TX and RX queues.
module spi_fifo
    import spi_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int AddrWidth = FIFO_ADDR_WIDTH
) (
    input  logic                 Clk_i,
    input  logic                 Reset_n_i,
    input  logic [DataWidth-1:0] Data_i,
    input  logic                 Write_i,
    input  logic                 ReadNext_i,
    output logic [DataWidth-1:0] Data_o,
    output logic                 Full_o,
    output logic                 Empty_o
);

    localparam int Depth = 1 << AddrWidth;
    localparam logic [AddrWidth:0] FullCount = {1'b1, {AddrWidth{1'b0}}};

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   count;
    logic                 do_write;
    logic                 do_read;

    assign Full_o   = (count == FullCount);
    assign Empty_o  = (count == '0);
    assign do_write = Write_i && !Full_o;
    assign do_read  = ReadNext_i && !Empty_o;

    // When empty, keep presenting the most recently popped word so the output stays stable.
    assign Data_o = Empty_o ? mem[rd_ptr - 1'b1] : mem[rd_ptr];

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= Data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master: TX/RX FIFOs around a prescaled SCK generator, shifter and FSM.
module spi_master
    import spi_pkg::*;
#(
    parameter int DataWidth     = DATA_WIDTH,
    parameter int FIFOAddrWidth = FIFO_ADDR_WIDTH,
    parameter int SPPRWidth     = SPPR_WIDTH,
    parameter int SPRWidth      = SPR_WIDTH
) (
    input  logic                 Clk_i,
    input  logic                 Reset_n_i,
    input  logic                 CPOL_i,
    input  logic                 CPHA_i,
    input  logic                 LSBFE_i,
    input  logic [SPPRWidth-1:0] SPPR_i,
    input  logic [SPRWidth-1:0]  SPR_i,
    input  logic [DataWidth-1:0] Data_i,
    input  logic                 Write_i,
    input  logic                 ReadNext_i,
    output logic [DataWidth-1:0] Data_o,
    output logic                 FIFOFull_o,
    output logic                 FIFOEmpty_o,
    output logic                 Transmission_o,
    output logic                 SCK_o,
    output logic                 MOSI_o,
    input  logic                 MISO_i
);

    // Largest half period is 2**SPPRWidth << (2**SPRWidth - 1).
    localparam int HalfWidth = SPPRWidth + (1 << SPRWidth);
    localparam int EdgeWidth = $clog2(2 * DataWidth + 1);
    localparam logic [EdgeWidth-1:0] LastEdge = EdgeWidth'(2 * DataWidth);

    state_t               state;
    state_t               state_next;
    logic                 load;
    logic                 tick;

    logic [HalfWidth-1:0] half_in;
    logic [HalfWidth-1:0] half_q;
    logic [HalfWidth-1:0] div_cnt;
    logic [EdgeWidth-1:0] edge_cnt;
    logic                 cpol_q;
    logic                 cpha_q;
    logic                 lsbfe_q;
    logic [DataWidth-1:0] tx_shift;
    logic [DataWidth-1:0] rx_shift;
    logic                 sck_q;
    logic                 mosi_q;
    logic                 rx_push;

    logic [DataWidth-1:0] tx_head;
    logic                 tx_empty;
    logic                 rx_full;
    logic                 rx_write;

    logic                 sample_edge;
    logic                 last_edge;
    logic                 last_sample;

    assign half_in     = (HalfWidth'(SPPR_i) + 1'b1) << SPR_i;
    assign tick        = (div_cnt == half_q - 1'b1);
    // Even edge_cnt means the upcoming toggle is a leading edge.
    assign sample_edge = ~edge_cnt[0] ^ cpha_q;
    assign last_edge   = (edge_cnt == LastEdge - 1'b1);
    assign last_sample = (edge_cnt >= LastEdge - 2'd2);
    assign rx_write    = rx_push && !rx_full;

    spi_fifo #(
        .DataWidth (DataWidth),
        .AddrWidth (FIFOAddrWidth)
    ) u_tx_fifo (
        .Clk_i      (Clk_i),
        .Reset_n_i  (Reset_n_i),
        .Data_i     (Data_i),
        .Write_i    (Write_i),
        .ReadNext_i (load),
        .Data_o     (tx_head),
        .Full_o     (FIFOFull_o),
        .Empty_o    (tx_empty)
    );

    spi_fifo #(
        .DataWidth (DataWidth),
        .AddrWidth (FIFOAddrWidth)
    ) u_rx_fifo (
        .Clk_i      (Clk_i),
        .Reset_n_i  (Reset_n_i),
        .Data_i     (rx_shift),
        .Write_i    (rx_write),
        .ReadNext_i (ReadNext_i),
        .Data_o     (Data_o),
        .Full_o     (rx_full),
        .Empty_o    (FIFOEmpty_o)
    );

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state <= stIdle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            stIdle: begin
                if (!tx_empty) begin
                    load       = 1'b1;
                    state_next = stShift;
                end
            end
            stShift: begin
                if (tick && last_edge) begin
                    state_next = stGap;
                end
            end
            stGap: begin
                if (tick) begin
                    if (!tx_empty) begin
                        load       = 1'b1;
                        state_next = stShift;
                    end else begin
                        state_next = stIdle;
                    end
                end
            end
            default: state_next = stIdle;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            half_q   <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsbfe_q  <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            rx_push  <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (load) begin
                cpol_q   <= CPOL_i;
                cpha_q   <= CPHA_i;
                lsbfe_q  <= LSBFE_i;
                half_q   <= half_in;
                div_cnt  <= '0;
                edge_cnt <= '0;
                sck_q    <= CPOL_i;
                if (CPHA_i) begin
                    tx_shift <= tx_head;
                end else begin
                    // CPHA=0 puts the first bit out before the first edge.
                    mosi_q   <= LSBFE_i ? tx_head[0] : tx_head[DataWidth-1];
                    tx_shift <= LSBFE_i ? (tx_head >> 1) : (tx_head << 1);
                end
            end else begin
                case (state)
                    stShift: begin
                        if (tick) begin
                            div_cnt  <= '0;
                            edge_cnt <= edge_cnt + 1'b1;
                            sck_q    <= ~sck_q;
                            if (sample_edge) begin
                                rx_shift <= lsbfe_q ? {MISO_i, rx_shift[DataWidth-1:1]}
                                                    : {rx_shift[DataWidth-2:0], MISO_i};
                                rx_push  <= last_sample;
                            end else if (!last_edge) begin
                                mosi_q   <= lsbfe_q ? tx_shift[0] : tx_shift[DataWidth-1];
                                tx_shift <= lsbfe_q ? (tx_shift >> 1) : (tx_shift << 1);
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    stGap: begin
                        sck_q   <= cpol_q;
                        div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    end
                    default: begin
                        sck_q <= CPOL_i;
                    end
                endcase
            end
        end
    end

    assign SCK_o          = sck_q;
    assign MOSI_o         = mosi_q;
    assign Transmission_o = !tx_empty || (state != stIdle);

endmodule

// File: tb/tb_spi_master.sv
// Directed-plus-random bench for spi_master with a frame-level reference model.
module tb_spi_master;

    logic       clk;
    logic       rst_n;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic [7:0] data_in;
    logic       write;
    logic       read_next;
    logic [7:0] data_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       transmission;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       miso_loop;
    logic       miso_level;

    int tests;
    int fails;
    int cyc;
    int last_edge_cyc;
    logic [7:0] exp_q[$];

    assign miso = miso_loop ? mosi : miso_level;

    spi_master dut (
        .Clk_i          (clk),
        .Reset_n_i      (rst_n),
        .CPOL_i         (cpol),
        .CPHA_i         (cpha),
        .LSBFE_i        (lsbfe),
        .SPPR_i         (sppr),
        .SPR_i          (spr),
        .Data_i         (data_in),
        .Write_i        (write),
        .ReadNext_i     (read_next),
        .Data_o         (data_out),
        .FIFOFull_o     (fifo_full),
        .FIFOEmpty_o    (fifo_empty),
        .Transmission_o (transmission),
        .SCK_o          (sck),
        .MOSI_o         (mosi),
        .MISO_i         (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is aligned to a falling edge; the byte is presented for exactly one rising edge.
    task automatic write_byte(input logic [7:0] b);
        data_in = b;
        write   = 1'b1;
        @(negedge clk);
        write   = 1'b0;
    endtask

    task automatic set_cfg(input logic p, input logic h, input logic l, input logic [2:0] a, input logic [2:0] s);
        cpol  = p;
        cpha  = h;
        lsbfe = l;
        sppr  = a;
        spr   = s;
        repeat (2) @(negedge clk);
        check("idle_sck_follows_cpol", 32'(sck), 32'(p));
    endtask

    // Follows one 16-edge frame: half-period spacing and MOSI at every sampling edge.
    task automatic watch_frame(input logic [7:0] b, input logic p, input logic h,
                               input logic l, input int hp, input bit chk_gap);
        logic prev;
        logic exp_bit;
        int   waited;
        int   j;
        prev = p;
        for (int k = 1; k <= 16; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (sck === prev && waited < 4 * hp + 8);
            if (sck === prev) begin
                check($sformatf("edge%0d_timeout", k), 32'(1), 32'(0));
                break;
            end
            prev = sck;
            if (k > 1) check("half_period", 32'(cyc - last_edge_cyc), 32'(hp));
            else if (chk_gap) check("gap_then_first_edge", 32'(cyc - last_edge_cyc), 32'(2 * hp));
            last_edge_cyc = cyc;
            if (((k % 2) == 1) != h) begin
                j       = (k - 1) / 2;
                exp_bit = l ? b[j] : b[7 - j];
                check($sformatf("mosi_bit%0d", j), 32'(mosi), 32'(exp_bit));
            end
        end
    endtask

    task automatic wait_trans_low(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            if (!transmission) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        check("transmission_falls", 32'(done), 32'(1));
    endtask

    // Pops every RX byte as soon as it appears and compares against the model queue.
    task automatic drain_rx(input int budget);
        bit done;
        logic [7:0] e;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!fifo_empty) begin
                if (exp_q.size() == 0) begin
                    check("rx_unexpected_byte", 32'(data_out), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_byte", 32'(data_out), 32'(e));
                end
                read_next = 1'b1;
            end else begin
                read_next = 1'b0;
                if (!transmission) begin
                    done = 1;
                    break;
                end
            end
        end
        read_next = 1'b0;
        check("drain_done", 32'(done), 32'(1));
        check("rx_missing_bytes", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] bytes[5];
        logic [7:0] last_head;
        logic [1:0] mode;
        logic       prev;
        int         n;
        int         waited;
        int         hp;
        bit         freed;

        tests = 0; fails = 0; last_edge_cyc = 0;
        rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = '0; spr = '0;
        data_in = '0; write = 1'b0; read_next = 1'b0; miso_loop = 1'b1; miso_level = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck), 32'(0));
        check("rst_mosi", 32'(mosi), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        check("rst_full", 32'(fifo_full), 32'(0));
        check("rst_empty", 32'(fifo_empty), 32'(1));
        check("rst_trans", 32'(transmission), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback of 0xA5, mode 0, MSB first, Clk/2
        set_cfg(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        write_byte(8'hA5);
        check("t1_trans_high", 32'(transmission), 32'(1));
        watch_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1, 0);
        wait_trans_low(20);
        check("t1_rx_ready_at_fall", 32'(fifo_empty), 32'(0));
        check("t1_rx_value_at_fall", 32'(data_out), 32'hA5);
        check("t1_sck_idle", 32'(sck), 32'(0));
        exp_q.push_back(8'hA5);
        drain_rx(20);

        // Back-to-back frames with MISO tied high
        miso_loop = 1'b0; miso_level = 1'b1;
        write_byte(8'h12);
        write_byte(8'h34);
        watch_frame(8'h12, 1'b0, 1'b0, 1'b0, 1, 0);
        watch_frame(8'h34, 1'b0, 1'b0, 1'b0, 1, 1);
        wait_trans_low(20);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        drain_rx(20);

        // All four clock modes, LSB first, H = 4
        miso_loop = 1'b1;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            set_cfg(mode[1], mode[0], 1'b1, 3'd1, 3'd1);
            write_byte(8'h01);
            watch_frame(8'h01, mode[1], mode[0], 1'b1, 4, 0);
            exp_q.push_back(8'h01);
            drain_rx(40);
        end

        // TX FIFO fills behind a very slow frame; overflow is dropped
        set_cfg(1'b0, 1'b0, 1'b0, 3'd7, 3'd7);
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom);
            write_byte(bytes[i]);
            exp_q.push_back(bytes[i]);
        end
        check("t4_full_after_4_buffered", 32'(fifo_full), 32'(1));
        write_byte(8'($urandom));
        check("t4_full_after_drop", 32'(fifo_full), 32'(1));
        sppr = 3'd0; spr = 3'd0;
        watch_frame(bytes[0], 1'b0, 1'b0, 1'b0, 1024, 0);
        freed = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!fifo_full) begin
                freed = 1;
                break;
            end
            @(negedge clk);
        end
        check("t4_full_clears", 32'(freed), 32'(1));
        check("t4_full_clears_after_gap", 32'(cyc - last_edge_cyc), 32'(1024));
        b = 8'($urandom);
        write_byte(b);
        exp_q.push_back(b);
        check("t4_refilled", 32'(fifo_full), 32'(1));
        drain_rx(400);

        // RX overflow: five frames, nobody reading
        for (int i = 0; i < 5; i++) begin
            bytes[i] = 8'($urandom);
            write_byte(bytes[i]);
        end
        wait_trans_low(300);
        for (int i = 0; i < 4; i++) begin
            check("t5_rx_nonempty", 32'(fifo_empty), 32'(0));
            check($sformatf("t5_rx%0d", i), 32'(data_out), 32'(bytes[i]));
            read_next = 1'b1;
            @(negedge clk);
            read_next = 1'b0;
        end
        check("t5_rx_empty", 32'(fifo_empty), 32'(1));
        check("t5_last_head", 32'(data_out), 32'(bytes[3]));
        read_next = 1'b1;
        @(negedge clk);
        read_next = 1'b0;
        check("t5_pop_empty_holds", 32'(data_out), 32'(bytes[3]));
        check("t5_pop_empty_still_empty", 32'(fifo_empty), 32'(1));

        // Random configurations and MISO sources
        for (int r = 0; r < 8; r++) begin
            mode = 2'($urandom_range(0, 2));
            set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 2)), 3'($urandom_range(0, 1)));
            hp = (int'(sppr) + 1) << spr;
            miso_loop  = (mode == 2'd0);
            miso_level = (mode == 2'd1);
            b = 8'($urandom);
            write_byte(b);
            watch_frame(b, cpol, cpha, lsbfe, hp, 0);
            exp_q.push_back(mode == 2'd0 ? b : (mode == 2'd1 ? 8'hFF : 8'h00));
            drain_rx(4 * hp + 20);
        end
        miso_loop = 1'b1;

        // Reset in the middle of a frame
        set_cfg(1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
        write_byte(8'($urandom));
        prev = 1'b1; n = 0; waited = 0;
        while (n < 5 && waited < 200) begin
            @(negedge clk);
            waited++;
            if (sck !== prev) begin
                prev = sck;
                n++;
            end
        end
        check("t6_reached_edge5", 32'(n), 32'(5));
        last_head = 8'hFF;
        rst_n = 1'b0;
        #1;
        check("t6_rst_sck", 32'(sck), 32'(0));
        check("t6_rst_mosi", 32'(mosi), 32'(0));
        check("t6_rst_data", 32'(data_out), 32'(0));
        check("t6_rst_full", 32'(fifo_full), 32'(0));
        check("t6_rst_empty", 32'(fifo_empty), 32'(1));
        check("t6_rst_trans", 32'(transmission), 32'(0));
        @(negedge clk);
        check("t6_rst_hold_sck", 32'(sck), 32'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_partial_push", 32'(fifo_empty), 32'(1));
        check("t6_idle_after_rst", 32'(transmission), 32'(0));
        check("t6_sck_follows_cpol", 32'(sck), 32'(1));
        b = 8'($urandom);
        write_byte(b);
        watch_frame(b, 1'b1, 1'b0, 1'b0, 4, 0);
        exp_q.push_back(b);
        drain_rx(60);
        check("t6_unused_marker", 32'(last_head), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
